// File: rtl/data_proc_pkg.sv
// Shared constants and types for the data_proc frame sequencer.
// CSR map, bit positions, FSM state encoding and MODE width.
package data_proc_pkg;

  localparam int MODE_W = 2;

  localparam logic [1:0] ADDR_CTRL      = 2'd0;
  localparam logic [1:0] ADDR_STATUS    = 2'd1;
  localparam logic [1:0] ADDR_FRAME_CNT = 2'd2;
  localparam logic [1:0] ADDR_IRQ_EN    = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_ABORT = 2;
  localparam int CTRL_FLUSH = 3;
  localparam int CTRL_MODE  = 4;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/data_proc_csr.sv
// CSR file: CTRL/STATUS/FRAME_CNT/IRQ_EN, sticky W1C flags, irq, read mux.
// Ports: cfg_* bus, FSM status in (busy/done_set/abort_set/frame_cnt), control out.
module data_proc_csr
  import data_proc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_we,
  input  logic              cfg_re,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  input  logic              busy,
  input  logic              done_set,
  input  logic              abort_set,
  input  logic [CNT_W-1:0]  frame_cnt,
  output logic              start_pulse,
  output logic              abort_pulse,
  output logic              cont,
  output logic              flush_idle,
  output logic [MODE_W-1:0] cfg_mode,
  output logic              irq
);

  logic              cont_q, cont_d;
  logic              flush_q, flush_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              done_q, done_d;
  logic              abrt_q, abrt_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
  logic [31:0]       rdata_q, rdata_d;

  logic ctrl_wr, stat_wr, ien_wr;
  logic unused_wdata;

  assign ctrl_wr = cfg_we & (cfg_addr == ADDR_CTRL);
  assign stat_wr = cfg_we & (cfg_addr == ADDR_STATUS);
  assign ien_wr  = cfg_we & (cfg_addr == ADDR_IRQ_EN);

  assign start_pulse = ctrl_wr & cfg_wdata[CTRL_START];
  assign abort_pulse = ctrl_wr & cfg_wdata[CTRL_ABORT];
  assign unused_wdata = ^cfg_wdata[31:6];

  always_comb begin
    cont_d   = cont_q;
    flush_d  = flush_q;
    mode_d   = mode_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr) begin
      cont_d  = cfg_wdata[CTRL_CONT];
      flush_d = cfg_wdata[CTRL_FLUSH];
      mode_d  = cfg_wdata[CTRL_MODE +: MODE_W];
    end
    if (ien_wr) irq_en_d = cfg_wdata[0];
    // a hardware set in the same cycle as a W1C wins
    done_d = done_set
           | (done_q & ~(stat_wr & cfg_wdata[STAT_DONE]));
    abrt_d = abort_set
           | (abrt_q & ~(stat_wr & cfg_wdata[STAT_ABORTED]));
    irq_d  = done_d & irq_en_d;
  end

  // reads see the pre-write register values
  always_comb begin
    rdata_d = rdata_q;
    if (cfg_re) begin
      unique case (cfg_addr)
        ADDR_CTRL:
          rdata_d = 32'({mode_q, flush_q, 1'b0, cont_q, 1'b0});
        ADDR_STATUS:
          rdata_d = 32'({abrt_q, done_q, busy});
        ADDR_FRAME_CNT:
          rdata_d = 32'(frame_cnt);
        ADDR_IRQ_EN:
          rdata_d = 32'(irq_en_q);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cont_q   <= 1'b0;
      flush_q  <= 1'b0;
      mode_q   <= '0;
      done_q   <= 1'b0;
      abrt_q   <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      cont_q   <= cont_d;
      flush_q  <= flush_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      abrt_q   <= abrt_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  // write-through so START+MODE in one write loads the new mode
  assign cfg_mode   = mode_d;
  assign cont       = cont_q;
  assign flush_idle = flush_q;
  assign irq        = irq_q;
  assign cfg_rdata  = rdata_q;

endmodule

// File: rtl/data_proc_ctrl.sv
// Frame sequencer: gates the pixel stream, counts x/y, emits sof/eol/eof.
// Ports: clk/rstn, cfg_* CSR bus, s_* upstream, m_* downstream, mode/busy/irq.
module data_proc_ctrl
  import data_proc_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_we,
  input  logic              cfg_re,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  input  logic [7:0]        s_pixel,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [7:0]        m_pixel,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic [MODE_W-1:0] proc_mode,
  output logic              busy,
  output logic              irq
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  x_q, x_d;
  logic [CNT_W-1:0]  y_q, y_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic [MODE_W-1:0] mode_q, mode_d;

  logic              start, abort, cont, flush_idle;
  logic [MODE_W-1:0] cfg_mode;
  logic              xfer, last_x, last_y, last_px;

  data_proc_csr #(.CNT_W(CNT_W)) u_csr (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_we      (cfg_we),
    .cfg_re      (cfg_re),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata),
    .busy        (busy),
    .done_set    (state_q == DONE),
    .abort_set   ((state_q == RUN) & abort),
    .frame_cnt   (fcnt_q),
    .start_pulse (start),
    .abort_pulse (abort),
    .cont        (cont),
    .flush_idle  (flush_idle),
    .cfg_mode    (cfg_mode),
    .irq         (irq)
  );

  assign xfer    = m_valid & m_ready;
  assign last_x  = x_q == CNT_W'(IMG_W - 1);
  assign last_y  = y_q == CNT_W'(IMG_H - 1);
  assign last_px = xfer & last_x & last_y;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // abort outranks a same-cycle last pixel
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start & ~abort) state_d = RUN;
      RUN:     if (abort)          state_d = IDLE;
               else if (last_px)   state_d = DONE;
      DONE:    state_d = cont ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      IDLE:    s_ready = flush_idle;
      RUN: begin
        s_ready = m_ready;
        m_valid = s_valid;
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    fcnt_d = fcnt_q;
    mode_d = mode_q;
    if (state_q == RUN) begin
      if (abort) begin
        x_d = '0;
        y_d = '0;
      end else if (xfer) begin
        x_d = last_x ? '0 : x_q + CNT_W'(1);
        if (last_x) y_d = last_y ? '0 : y_q + CNT_W'(1);
      end
    end
    if (state_q == DONE) fcnt_d = fcnt_q + CNT_W'(1);
    if (state_d == RUN && state_q != RUN) mode_d = cfg_mode;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q    <= '0;
      y_q    <= '0;
      fcnt_q <= '0;
      mode_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      fcnt_q <= fcnt_d;
      mode_q <= mode_d;
    end
  end

  assign m_pixel   = s_pixel;
  assign m_sof     = m_valid & (x_q == '0) & (y_q == '0);
  assign m_eol     = m_valid & last_x;
  assign m_eof     = m_valid & last_x & last_y;
  assign proc_mode = mode_q;

endmodule

// File: tb/tb_data_proc_ctrl.sv
// Scoreboard bench for data_proc_ctrl with a 4x2 frame.
// Driver queues expected pixels; a negedge monitor checks every transfer.
module tb_data_proc_ctrl;
  import data_proc_pkg::*;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_we = 1'b0;
  logic        cfg_re = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic [7:0]  s_pixel = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  m_pixel;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_sof, m_eol, m_eof;
  logic [1:0]  proc_mode;
  logic        busy, irq;

  data_proc_ctrl #(.IMG_W(W), .IMG_H(H), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
    .m_pixel(m_pixel), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .proc_mode(proc_mode), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
    logic       eof;
    logic [1:0] mode;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   frames = 0;
  bit   st_done = 0;
  bit   irq_en_m = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL extra_pixel: got 0x%0h expected none", m_pixel);
      end else begin
        mon_e = exp_q.pop_front();
        check("pixel{pix,sof,eol,eof,mode}",
              32'({m_pixel, m_sof, m_eol, m_eof, proc_mode}),
              32'(mon_e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    if (a == ADDR_STATUS && d[1]) st_done = 0;
    if (a == ADDR_IRQ_EN) irq_en_m = d[0];
  endtask

  task automatic csr_rd(input string nm, input logic [1:0] a,
                        input logic [31:0] exp);
    cfg_re = 1'b1;
    cfg_addr = a;
    tick();
    cfg_re = 1'b0;
    check(nm, cfg_rdata, exp);
  endtask

  task automatic send_pixel(input logic [7:0] p, input bit bp);
    bit ok = 0;
    s_pixel = p;
    s_valid = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      m_ready = bp ? ~m_ready : 1'b1;
      @(negedge clk);
      check("s_ready_mirror", 32'(s_ready), 32'(m_ready));
      ok = s_valid & s_ready;
      tick();
      cfg_we = 1'b0;
    end
    s_valid = 1'b0;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got no s_ready expected accept");
    end
  endtask

  task automatic push_pixel(input int i, input logic [7:0] p,
                            input logic [1:0] mode);
    exp_q.push_back({p, 1'(i == 0), 1'(i % W == W - 1),
                     1'(i == N - 1), mode});
  endtask

  task automatic send_frame(input logic [1:0] mode, input bit bp,
                            input bit seq, input int wr_at,
                            input logic [31:0] wr_d);
    logic [7:0] p;
    for (int i = 0; i < N; i++) begin
      p = seq ? 8'(8'h10 + i) : 8'($urandom);
      push_pixel(i, p, mode);
      if (i == wr_at) begin
        cfg_we = 1'b1;
        cfg_addr = ADDR_CTRL;
        cfg_wdata = wr_d;
      end
      send_pixel(p, bp);
    end
    s_valid = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    check("done_busy", 32'(busy), 32'd0);
    check("done_s_ready", 32'(s_ready), 32'd0);
    check("done_m_valid", 32'(m_valid), 32'd0);
    check("done_irq", 32'(irq), 32'(st_done & irq_en_m));
    tick();
    s_valid = 1'b0;
    frames++;
    st_done = 1;
    check("irq_after_done", 32'(irq), 32'(irq_en_m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] p;
    rstn = 1'b0;
    s_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", cfg_rdata, 32'd0);
    check("rst_mode", 32'(proc_mode), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    s_valid = 1'b0;
    rstn = 1'b1;
    tick();
    csr_rd("fcnt_reset", ADDR_FRAME_CNT, 32'd0);
    csr_rd("status_reset", ADDR_STATUS, 32'd0);

    // single frame, sequential pixels
    csr_wr(ADDR_CTRL, 32'h01);
    check("busy_after_start", 32'(busy), 32'd1);
    send_frame(2'd0, 1'b0, 1'b1, -1, 32'd0);
    s_valid = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_s_ready", 32'(s_ready), 32'd0);
    tick();
    s_valid = 1'b0;
    csr_rd("fcnt_1", ADDR_FRAME_CNT, 32'(frames));
    csr_rd("status_done", ADDR_STATUS, 32'h2);

    // backpressure
    csr_wr(ADDR_STATUS, 32'h2);
    csr_wr(ADDR_CTRL, 32'h01);
    send_frame(2'd0, 1'b1, 1'b0, -1, 32'd0);
    csr_rd("fcnt_bp", ADDR_FRAME_CNT, 32'(frames));

    // continuous, mode change mid frame 2, cont cleared in frame 3
    csr_wr(ADDR_CTRL, 32'h23);
    send_frame(2'd2, 1'b0, 1'b0, -1, 32'd0);
    send_frame(2'd2, 1'b1, 1'b0, 3, 32'h12);
    send_frame(2'd1, 1'b0, 1'b0, 5, 32'h10);
    check("cont_end_idle", 32'(busy), 32'd0);
    csr_rd("fcnt_cont", ADDR_FRAME_CNT, 32'(frames));
    csr_rd("ctrl_readback", ADDR_CTRL, 32'h10);

    // abort after 5 pixels
    csr_wr(ADDR_STATUS, 32'h6);
    csr_wr(ADDR_CTRL, 32'h01);
    for (int i = 0; i < 5; i++) begin
      p = 8'($urandom);
      push_pixel(i, p, 2'd0);
      send_pixel(p, 1'b0);
    end
    csr_wr(ADDR_CTRL, 32'h04);
    check("abort_busy", 32'(busy), 32'd0);
    csr_rd("status_aborted", ADDR_STATUS, 32'h4);
    csr_rd("fcnt_abort", ADDR_FRAME_CNT, 32'(frames));
    csr_wr(ADDR_STATUS, 32'h4);
    csr_wr(ADDR_CTRL, 32'h01);
    send_frame(2'd0, 1'b0, 1'b0, -1, 32'd0);

    // abort on the last pixel
    csr_wr(ADDR_CTRL, 32'h01);
    for (int i = 0; i < N; i++) begin
      p = 8'($urandom);
      push_pixel(i, p, 2'd0);
      if (i == N - 1) begin
        cfg_we = 1'b1;
        cfg_addr = ADDR_CTRL;
        cfg_wdata = 32'h04;
      end
      send_pixel(p, 1'b0);
    end
    check("abort_last_busy", 32'(busy), 32'd0);
    csr_rd("abort_last_status", ADDR_STATUS, 32'h6);
    csr_rd("abort_last_fcnt", ADDR_FRAME_CNT, 32'(frames));
    csr_wr(ADDR_STATUS, 32'h6);

    // start and abort together
    csr_wr(ADDR_CTRL, 32'h05);
    check("start_abort_busy", 32'(busy), 32'd0);
    csr_rd("start_abort_status", ADDR_STATUS, 32'h0);

    // interrupt
    csr_wr(ADDR_IRQ_EN, 32'h1);
    csr_wr(ADDR_CTRL, 32'h01);
    send_frame(2'd0, 1'b0, 1'b0, -1, 32'd0);
    csr_wr(ADDR_STATUS, 32'h2);
    check("irq_w1c", 32'(irq), 32'd0);

    // flush in idle, then a frame starting at sof
    csr_wr(ADDR_CTRL, 32'h08);
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_pixel = 8'($urandom);
      @(negedge clk);
      check("flush_s_ready", 32'(s_ready), 32'd1);
      check("flush_m_valid", 32'(m_valid), 32'd0);
      tick();
    end
    s_valid = 1'b0;
    csr_wr(ADDR_CTRL, 32'h09);
    send_frame(2'd0, 1'b0, 1'b0, -1, 32'd0);
    csr_rd("fcnt_flush", ADDR_FRAME_CNT, 32'(frames));

    // reset mid frame
    csr_wr(ADDR_CTRL, 32'h31);
    for (int i = 0; i < 3; i++) begin
      p = 8'($urandom);
      push_pixel(i, p, 2'd3);
      send_pixel(p, 1'b0);
    end
    csr_rd("fcnt_pre_rst", ADDR_FRAME_CNT, 32'(frames));
    s_valid = 1'b1;
    #1 rstn = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_s_ready", 32'(s_ready), 32'd0);
    check("arst_m_valid", 32'(m_valid), 32'd0);
    check("arst_irq", 32'(irq), 32'd0);
    check("arst_mode", 32'(proc_mode), 32'd0);
    check("arst_rdata", cfg_rdata, 32'd0);
    tick();
    rstn = 1'b1;
    s_valid = 1'b0;
    frames = 0;
    st_done = 0;
    irq_en_m = 0;
    tick();
    csr_rd("fcnt_after_rst", ADDR_FRAME_CNT, 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_proc_ctrl.md
Name: data_proc_ctrl

Overview:
- Frame sequencer between the pixel stream entering the clk domain and data_proc.
- Gates the valid/ready stream and counts pixels into lines and frames.
- Generates sof/eol/eof sidebands, latches the processing mode per frame, and reports status over a small CSR port.
- Runs entirely in the 100 MHz clk domain. The upstream stream has already crossed from sensor_clk.

Parameters:
- IMG_W, 32, pixels per line (>=2)
- IMG_H, 32, lines per frame (>=1)
- CNT_W, 16, width of the x/y counters and FRAME_CNT

Ports:
- clk  in  1  processing clock
- rstn  in  1  asynchronous active-low reset
- cfg_we  in  1  CSR write strobe
- cfg_re  in  1  CSR read strobe
- cfg_addr  in  2  CSR word address
- cfg_wdata  in  32  CSR write data
- cfg_rdata  out  32  CSR read data, valid the cycle after cfg_re
- s_pixel  in  8  upstream pixel
- s_valid  in  1  upstream valid
- s_ready  out  1  upstream ready
- m_pixel  out  8  pixel to data_proc
- m_valid  out  1  valid to data_proc
- m_ready  in  1  ready from data_proc
- m_sof  out  1  first pixel of frame
- m_eol  out  1  last pixel of line
- m_eof  out  1  last pixel of frame
- proc_mode  out  2  mode for data_proc, stable within a frame
- busy  out  1  high in RUN
- irq  out  1  level interrupt

Behaviour:
- Reset (asynchronous, rstn low): state=IDLE; x, y and FRAME_CNT =0; all CSR bits =0; cfg_rdata=0; proc_mode=0; irq=0.
- CSR map:
  - addr0 CTRL: bit0 START (write-only pulse), bit1 CONT, bit2 ABORT (write-only pulse), bit3 FLUSH_IDLE, bits5:4 MODE.
  - addr1 STATUS: bit0 busy (RO), bit1 DONE (sticky, W1C), bit2 ABORTED (sticky, W1C).
  - addr2 FRAME_CNT (RO, wraps at 2^CNT_W).
  - addr3 IRQ_EN bit0.
  - Unmapped bits read 0.
- States:
  - IDLE: on START -> RUN.
  - RUN: on last-pixel handshake -> DONE; on ABORT -> IDLE.
  - DONE (exactly 1 cycle): FRAME_CNT+1 and DONE set; then -> RUN if CONT=1, else -> IDLE.
- Write latency: a CTRL write at cycle N takes effect at N+1. START at N gives busy=1 and s_ready eligible at N+1.
- proc_mode: loaded from CTRL.MODE on the IDLE->RUN and DONE->RUN transitions only. MODE writes mid-frame do not affect the current frame.
- Handshake in RUN: m_valid=s_valid, s_ready=m_ready, m_pixel=s_pixel (combinational). Transfer = m_valid & m_ready.
- Handshake in DONE: s_ready=0 and m_valid=0.
- Handshake in IDLE:
  - m_valid=0.
  - s_ready=FLUSH_IDLE; flushed pixels are discarded and not counted.
- Counters:
  - On transfer, x increments.
  - When x==IMG_W-1, x wraps to 0 and y increments.
  - The transfer with x==IMG_W-1 and y==IMG_H-1 is the last pixel; x and y both return to 0.
- Sidebands (combinational, qualified by m_valid):
  - m_sof = (x==0 & y==0).
  - m_eol = (x==IMG_W-1).
  - m_eof = m_eol & (y==IMG_H-1).
- ABORT in RUN:
  - The next cycle is IDLE with x=y=0 and ABORTED set; the frame is not counted.
  - ABORT beats a same-cycle last-pixel transfer: that pixel is still passed downstream, but DONE is not entered and FRAME_CNT does not increment.
- ABORT in IDLE sets nothing. START and ABORT in the same write: ABORT wins and the block stays IDLE.
- START while RUN or DONE is ignored.
- Clearing CONT mid-frame: the current frame completes, then the block goes to IDLE.
- irq: registered, irq = DONE & IRQ_EN[0]. Writing 1 to STATUS bit1 drops irq the cycle after the write. If DONE sets in the same cycle as a W1C, the set wins.
- Reads: cfg_rdata is registered and holds its value until the next cfg_re. A read of STATUS in the same cycle as a write returns the pre-write value.

Decomposition:
- Package data_proc_pkg holds:
  - CSR address constants (ADDR_CTRL, ADDR_STATUS, ADDR_FRAME_CNT, ADDR_IRQ_EN)
  - CTRL/STATUS bit-position constants
  - the state enum (IDLE, RUN, DONE)
  - MODE width
- Natural sub-module: data_proc_csr, containing the register file, W1C/sticky logic and read mux. It exports control pulses and levels to the FSM and counter logic in data_proc_ctrl.

Test Plan:
- IMG_W=4, IMG_H=2: write CTRL=0x01 (START), then stream 8 pixels 0x10..0x17 with m_ready=1. Expect:
  - m_sof on 0x10; m_eol on 0x13 and 0x17; m_eof on 0x17
  - one DONE cycle; FRAME_CNT=1; STATUS=0x2; back to IDLE; s_ready=0 afterwards.
- Backpressure: toggle m_ready every cycle. Expect s_ready to mirror m_ready, no pixel loss or duplication, and the sideband positions unchanged.
- CONT=1, MODE=2, START: run 3 frames, writing MODE=1 during frame 2. Expect:
  - proc_mode=2 through the end of frame 2, then 1 from frame 3
  - FRAME_CNT=3 after frame 3.
- Abort: write ABORT after 5 of 8 pixels. Expect busy=0 next cycle, ABORTED=1, FRAME_CNT unchanged. After a new START, the next pixel carries m_sof.
- IRQ: IRQ_EN=1, complete a frame. Expect irq=1 one cycle after DONE. Write STATUS=0x2 and expect irq=0 next cycle.
- FLUSH_IDLE=1 in IDLE with s_valid=1: expect s_ready=1, m_valid=0 and x, y unchanged. Then assert rstn low mid-frame and expect all outputs to return to their reset values immediately.
